// File: rtl/mac_nch.sv
// mac_nch: channel-interleaved signed multiply-accumulate for time-multiplexed
// FIR filters. Each accepted sample multiplies a*b and loads or accumulates the
// product into one of NCH accumulators selected by ch. On the last term of a sum
// the accumulator is scaled by 2^-S, rounded per RND, saturated to NBP bits and
// emitted with a one-cycle valid strobe.
//
// Ports:
//   c      clock, all logic on the rising edge
//   r      asynchronous active-high reset
//   iv     input valid; a, b, ch, first, last are only meaningful when iv=1
//   first  first term of a sum (load instead of accumulate)
//   last   last term of a sum (emit the result)
//   ch     accumulator index; samples with ch >= NCH are ignored
//   a, b   signed multiplicand / multiplier
//   ov     one-cycle strobe per completed sum
//   och    channel of the result on p (held while ov=0)
//   p      rounded, saturated result (held while ov=0)
//
// Latency: sample captured at edge n, product at n+1, accumulator at n+2,
// output register at n+3.
module mac_nch #(
   parameter int NBA = 24,
   parameter int NBB = 18,
   parameter int NBP = 24,
   parameter int S   = 17,
   parameter int G   = 6,
   parameter int NCH = 4,
   parameter int RND = 2,
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  c,
   input  logic                  r,
   input  logic                  iv,
   input  logic                  first,
   input  logic                  last,
   input  logic [CHW-1:0]        ch,
   input  logic signed [NBA-1:0] a,
   input  logic signed [NBB-1:0] b,
   output logic                  ov,
   output logic [CHW-1:0]        och,
   output logic signed [NBP-1:0] p
);

   localparam int NPR  = NBA + NBB;
   localparam int NACC = NPR + G;
   // one extra bit above the accumulator so floor+1 can never wrap before clamping
   localparam int QW   = NACC + 1;

   localparam logic [CHW:0]             NCH_L = (CHW+1)'(NCH);
   localparam logic [NACC-1:0]          ONE_A = {{(NACC-1){1'b0}}, 1'b1};
   localparam logic [NACC-1:0]          MASK  = (S == 0) ? {NACC{1'b0}} : ({NACC{1'b1}} >> (NACC - S));
   localparam logic [NACC-1:0]          HALF  = (S == 0) ? {NACC{1'b0}} : (ONE_A << ((S > 0) ? (S - 1) : 0));
   localparam logic signed [QW-1:0]     ONE_Q = {{(QW-1){1'b0}}, 1'b1};
   localparam logic signed [QW-1:0]     PMAX  = (ONE_Q <<< (NBP - 1)) - ONE_Q;
   localparam logic signed [QW-1:0]     PMIN  = -PMAX - ONE_Q;

   // Scale by 2^-S with the selected rounding, then clamp to the NBP-bit range.
   function automatic logic signed [NBP-1:0] round_sat(input logic signed [NACC-1:0] x);
      logic signed [QW-1:0] fl;
      logic signed [QW-1:0] q;
      logic [NACC-1:0]      rem;
      logic                 inc;
      fl  = {x[NACC-1], x};
      fl  = fl >>> S;          // arithmetic shift == floor division
      rem = x & MASK;          // always the non-negative remainder
      case (RND)
         32'sd0:  inc = 1'b0;
         32'sd1:  inc = (rem >= HALF);
         32'sd2:  inc = (rem > HALF) || ((rem == HALF) && fl[0]);
         default: inc = 1'b0;
      endcase
      if (S == 0) begin
         q = fl;
      end else begin
         q = fl + signed'({{(QW-1){1'b0}}, inc});
      end
      if (q > PMAX) begin
         return PMAX[NBP-1:0];
      end else if (q < PMIN) begin
         return PMIN[NBP-1:0];
      end else begin
         return q[NBP-1:0];
      end
   endfunction

   // stage 1
   logic                  v1_r, f1_r, l1_r;
   logic [CHW-1:0]        ch1_r;
   logic signed [NBA-1:0] a1_r;
   logic signed [NBB-1:0] b1_r;
   // stage 2
   logic                  v2_r, f2_r, l2_r;
   logic [CHW-1:0]        ch2_r;
   logic signed [NPR-1:0] prod2_r;
   // stage 3
   logic signed [NACC-1:0] acc_r [NCH];
   logic                   v3_r;
   logic [CHW-1:0]         ch3_r;
   logic signed [NACC-1:0] x3_r;
   // combinational
   logic signed [NACC-1:0] prod_x_s;
   logic signed [NACC-1:0] sel_s;
   logic signed [NACC-1:0] nxt_s;
   logic signed [NBP-1:0]  p_s;

   // Input register: capture the sample and its control bits.
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         v1_r  <= 1'b0;
         f1_r  <= 1'b0;
         l1_r  <= 1'b0;
         ch1_r <= '0;
         a1_r  <= '0;
         b1_r  <= '0;
      end else begin
         v1_r  <= iv;
         f1_r  <= first;
         l1_r  <= last;
         ch1_r <= ch;
         a1_r  <= a;
         b1_r  <= b;
      end
   end

   // Product register; out-of-range channels are dropped here so nothing downstream sees them.
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         v2_r    <= 1'b0;
         f2_r    <= 1'b0;
         l2_r    <= 1'b0;
         ch2_r   <= '0;
         prod2_r <= '0;
      end else begin
         v2_r    <= v1_r && ({1'b0, ch1_r} < NCH_L);
         f2_r    <= f1_r;
         l2_r    <= l1_r;
         ch2_r   <= ch1_r;
         prod2_r <= a1_r * b1_r;
      end
   end

   // Select the addressed accumulator and form its next value (load or wrap-around add).
   always_comb begin
      prod_x_s = prod2_r;
      sel_s    = '0;
      for (int i = 0; i < NCH; i++) begin
         sel_s = (ch2_r == CHW'(i)) ? acc_r[i] : sel_s;
      end
      if (f2_r) begin
         nxt_s = prod_x_s;
      end else begin
         nxt_s = sel_s + prod_x_s;
      end
   end

   // Accumulator bank; the completed sum is also staged toward the output.
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         for (int i = 0; i < NCH; i++) begin
            acc_r[i] <= '0;
         end
         v3_r  <= 1'b0;
         ch3_r <= '0;
         x3_r  <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (v2_r && (ch2_r == CHW'(i))) begin
               acc_r[i] <= nxt_s;
            end
         end
         v3_r  <= v2_r & l2_r;
         ch3_r <= ch2_r;
         x3_r  <= nxt_s;
      end
   end

   assign p_s = round_sat(x3_r);

   // Output register: p and och hold their last result between strobes.
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         ov  <= 1'b0;
         och <= '0;
         p   <= '0;
      end else begin
         ov <= v3_r;
         if (v3_r) begin
            och <= ch3_r;
            p   <= p_s;
         end
      end
   end

endmodule
